instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Producer end of the control unit's instruction interface. Owns the PC and fetches 32-bit
//  LEGv8 words from instruction memory over a req/ack handshake. Queues them in a small buffer
//  and presents them, with their PC, to the control unit on a valid/ready handshake.
//  Applies PS-field redirects (BR, branch) that come back from the datapath.
// PARAMETERS
//  ADDR_W     64  PC / memory address width
//  INSTR_W    32  instruction width
//  RESET_PC   0   PC loaded on reset
//  BUF_DEPTH  2   fetch buffer entries (power of 2, >=2)
// PORTS
//  clk            in   1        clock, all state on posedge
//  rst            in   1        asynchronous, active-low reset
//  imem_req       out  1        fetch request; held until imem_ack
//  imem_addr      out  ADDR_W   fetch address; stable while imem_req=1
//  imem_ack       in   1        response strobe; imem_rdata valid this cycle
//  imem_rdata     in   INSTR_W  fetched word
//  instr_valid    out  1        instruction/instr_pc valid to control unit
//  instr_ready    in   1        control unit accepts the word this cycle
//  instruction    out  INSTR_W  head-of-buffer instruction
//  instr_pc       out  ADDR_W   PC of instruction
//  instr_pc4      out  ADDR_W   instr_pc+4 (BL link value)
//  redirect_ps    in   2        PS: 00 hold, 01 sequential, 10 PC<=redirect_a, 11 PC<=redirect_pc+(imm<<2)
//  redirect_a     in   ADDR_W   register target (BR)
//  redirect_pc    in   ADDR_W   PC of the branching instruction
//  redirect_imm   in   ADDR_W   sign-extended word offset
// BEHAVIOUR
//  Reset (rst=0, asserts immediately): pc=RESET_PC, imem_req=0, imem_addr=RESET_PC,
//   instr_valid=0, instruction=0, instr_pc=0, buffer empty, state=IDLE.
//  FSM: IDLE -> FETCH one cycle after reset release.
//   FETCH: imem_req=1 and imem_addr=pc only if count+1<=BUF_DEPTH; otherwise req=0 (stall).
//          The request is held until imem_ack.
//   ack in FETCH: push {rdata,pc}, pc<=pc+4. A new req may start the next cycle (1 outstanding max).
//   DRAIN: entered on redirect while req is outstanding without ack. req stays high, addr is unchanged.
//          On ack the word is discarded, then the FSM goes to FETCH at the pending target.
//  Redirect (ps=10/11) is sampled each cycle. ps=00/01 is a no-op.
//   target: ps=10 -> {redirect_a[ADDR_W-1:2],2'b00}; ps=11 -> redirect_pc+(redirect_imm<<2) mod 2^ADDR_W
//   On redirect: buffer flushed and pc<=target. Any handshake with instr_ready in that same cycle
//    completes first (that word is consumed), then the rest is flushed.
//   redirect + imem_ack same cycle: the ack'd word is discarded and the next req goes to target.
//   A redirect while in DRAIN replaces the pending target (latest wins).
//  Output: instr_valid=!empty. Pop when instr_valid&instr_ready.
//   instruction/instr_pc hold stable while valid&!ready. Push and pop in the same cycle are legal when full.
//  Latency: ack at cycle N -> instr_valid at N+1 (registered buffer). Redirect at N -> req to target at N+1,
//   or after DRAIN completes.
//  PC wraps modulo 2^ADDR_W with no error.
// STRUCTURE
//  Shared header legv8_defs.vh: PS_HOLD/PS_SEQ/PS_REG/PS_BR codes and FSM state encodings
//   (IDLE/FETCH/DRAIN), shared with ControlUnit.
//  Sub-module fetch_buffer: synchronous FIFO (BUF_DEPTH x (INSTR_W+ADDR_W)) with push, pop, flush,
//   count, full, empty. Flush takes priority over push; a pop in the flush cycle completes.
// TESTING
//  1 release reset, ack 1 cycle after each req, rdata=0x91019083 @0 -> req addr 0 on cycle 1;
//    instr_valid with 0x91019083, pc 0, pc4 4; next req addr 4.
//  2 instr_ready=0 for 6 cycles -> words @0,@4 buffered; imem_req low once full; ready=1 -> 0 then 4, in order.
//  3 ps=11, redirect_pc=0x10, imm=-2 -> buffer flushed; next imem_addr=0x08; first valid pc=0x08.
//  4 ps=10, redirect_a=0x103 -> next imem_addr=0x100.
//  5 redirect ps=10 a=0x40 while req@8 is waiting, ack 3 cycles later -> addr 8 held until ack;
//    word discarded, never valid; next req 0x40.
//  6 rst low mid-DRAIN -> all outputs at reset values the same cycle; after release first req at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   ps_e          : PS-field codes driven back from the datapath / control unit
//   fetch_state_e : fetch FSM states (IDLE / FETCH / DRAIN)
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    PS_HOLD = 2'b00,
    PS_SEQ  = 2'b01,
    PS_REG  = 2'b10,
    PS_BR   = 2'b11
  } ps_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DRAIN = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// fetch_buffer: synchronous FIFO of DEPTH entries x WIDTH bits.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_push / i_wdata    : write an entry
//   i_pop               : remove the head entry (o_rdata)
//   i_flush             : empty the FIFO; wins over push, a same-cycle pop is harmless
//   o_count/o_full/o_empty : occupancy
module fetch_buffer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 96
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_wdata;
        r_wp        <= r_wp + AW'(1);
      end
      if (i_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, fetches words over imem_req/imem_ack
// (one outstanding request), buffers them and hands them to the control unit
// over instr_valid/instr_ready. PS-field redirects flush the buffer and move
// the PC; a redirect that hits an un-acked request goes through DRAIN.
//   clk, rst                      : clock, asynchronous active-low reset
//   imem_req/imem_addr            : fetch request (held until imem_ack)
//   imem_ack/imem_rdata           : fetch response
//   instr_valid/instr_ready       : delivery handshake
//   instruction/instr_pc/instr_pc4: head-of-buffer word, its PC, PC+4
//   redirect_ps/_a/_pc/_imm       : PC redirect request from the datapath
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 64,
  parameter int unsigned        INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter int unsigned        BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  instr_pc4,
  input  logic [1:0]         redirect_ps,
  input  logic [ADDR_W-1:0]  redirect_a,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic [ADDR_W-1:0]  redirect_imm
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned DW = INSTR_W + ADDR_W;

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_addr;
  logic              r_req;

  ps_e               w_ps;
  logic              w_redir;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_seq;
  logic              w_push;
  logic              w_pop;
  logic              w_room;
  logic [DW-1:0]     w_head;
  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;

  assign w_ps     = ps_e'(redirect_ps);
  assign w_redir  = (w_ps == PS_REG) || (w_ps == PS_BR);
  assign w_target = (w_ps == PS_BR) ? redirect_pc + (redirect_imm << 2)
                                    : redirect_a & ~ADDR_W'(3);
  assign w_pc_seq = r_pc + ADDR_W'(4);

  assign w_push = (r_state == FETCH) && r_req && imem_ack && !w_redir;
  assign w_pop  = !w_empty && instr_ready;

  // Room for one more word after this cycle's push/pop settle.
  always_comb begin
    w_room = 1'b0;
    if (w_push) w_room = w_pop ? !w_full : (w_count < CW'(BUF_DEPTH - 1));
    else        w_room = w_pop || !w_full;
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (DW)
  ) u_fetch_buffer (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .i_wdata ({imem_rdata, r_addr}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // In DRAIN r_pc already holds the pending target while r_addr keeps the
  // address of the request still waiting for its ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= FETCH;
          r_req   <= 1'b1;
          if (w_redir) begin
            r_pc   <= w_target;
            r_addr <= w_target;
          end else begin
            r_addr <= r_pc;
          end
        end
        FETCH: begin
          if (w_redir) begin
            r_pc <= w_target;
            if (r_req && !imem_ack) begin
              r_state <= DRAIN;
            end else begin
              r_req  <= 1'b1;
              r_addr <= w_target;
            end
          end else if (r_req) begin
            if (imem_ack) begin
              r_pc   <= w_pc_seq;
              r_addr <= w_pc_seq;
              r_req  <= w_room;
            end
          end else if (w_room) begin
            r_req  <= 1'b1;
            r_addr <= r_pc;
          end
        end
        DRAIN: begin
          if (w_redir) r_pc <= w_target;
          if (imem_ack) begin
            r_state <= FETCH;
            r_req   <= 1'b1;
            r_addr  <= w_redir ? w_target : r_pc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr_valid = !w_empty;
  assign instruction = w_head[DW-1:ADDR_W];
  assign instr_pc    = w_head[ADDR_W-1:0];
  assign instr_pc4   = instr_pc + ADDR_W'(4);

endmodule
